// File: rtl/video_scale_cfg_ctrl.sv
// Scaler configuration controller: measures input resolution, qualifies it over
// STABLE_FRAMES frames, divides out 16.16 step factors and applies them at a frame end.
// Optional status counters (frm_cnt, err_cnt) are built when VSCALE_CFG_STATUS_EN is defined.
module video_scale_cfg_ctrl #(
  parameter int VOUT_XRES     = 640,
  parameter int VOUT_YRES     = 480,
  parameter int DEF_XRES      = 1920,
  parameter int DEF_YRES      = 1080,
  parameter int MAX_XRES      = 4096,
  parameter int MAX_YRES      = 2160,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        pixclk_in,
  input  logic        rst,
  input  logic        vs_in,
  input  logic        de_in,
  output logic [15:0] vin_xres,
  output logic [15:0] vin_yres,
  output logic [31:0] scaler_width,
  output logic [31:0] scaler_height,
  output logic        cfg_valid,
  output logic        cfg_update,
`ifdef VSCALE_CFG_STATUS_EN
  output logic        fmt_change,
  output logic [15:0] frm_cnt,
  output logic [15:0] err_cnt
`else
  output logic        fmt_change
`endif
);

  localparam logic [15:0] VOX = 16'(VOUT_XRES);
  localparam logic [15:0] VOY = 16'(VOUT_YRES);
  localparam logic [15:0] MXX = 16'(MAX_XRES);
  localparam logic [15:0] MXY = 16'(MAX_YRES);
  localparam logic [3:0]  STB = 4'(STABLE_FRAMES);
  localparam logic [31:0] RST_SW = 32'(((longint'(DEF_XRES)) << 16) / VOUT_XRES + 1);
  localparam logic [31:0] RST_SH = 32'(((longint'(DEF_YRES)) << 16) / VOUT_YRES + 1);

  typedef enum logic [2:0] {IDLE, MEAS, DIV_W, DIV_H, WAIT_VS} state_t;
  state_t state, nxt;

  logic        vs_d, de_d;
  logic [15:0] x_cnt, y_cnt, line_w, cand_w, cand_h;
  logic        frame_bad;
  logic [3:0]  stable_cnt;
  logic        frame_end, line_end, qual, frame_ok, cand_match, cand_chg;
  logic        div_load, apply, lock_lost;
  logic [31:0] dq, q_nxt, res_w, res_h;
  logic [15:0] rem, rem_nxt, dvsr;
  logic [16:0] rem_sh;
  logic        qbit;
  logic [4:0]  div_cnt;

  // Edge detectors follow the inputs even in reset so no false edge appears on release.
  always_ff @(posedge pixclk_in) begin
    vs_d <= vs_in;
    de_d <= de_in;
  end

  assign frame_end  = vs_in & ~vs_d;
  assign line_end   = de_d & ~de_in;
  assign qual       = frame_end && (state != IDLE);
  assign frame_ok   = !frame_bad && (line_w != 16'd0) && (y_cnt != 16'd0) &&
                      (line_w <= MXX) && (y_cnt <= MXY);
  assign cand_match = (line_w == cand_w) && (y_cnt == cand_h);
  assign cand_chg   = qual && frame_ok && !cand_match;

  always_ff @(posedge pixclk_in) begin
    if (rst || frame_end) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      line_w    <= '0;
      frame_bad <= 1'b0;
    end else if (line_end) begin
      x_cnt <= '0;
      if (y_cnt == 16'd0)       line_w    <= x_cnt;
      else if (x_cnt != line_w) frame_bad <= 1'b1;
      if (y_cnt != 16'hFFFF)    y_cnt     <= y_cnt + 16'd1;
    end else if (de_in && x_cnt != 16'hFFFF) begin
      x_cnt <= x_cnt + 16'd1;
    end
  end

  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      cand_w     <= '0;
      cand_h     <= '0;
      stable_cnt <= '0;
    end else if (qual) begin
      if (!frame_ok) begin
        stable_cnt <= '0;
      end else if (cand_match) begin
        if (stable_cnt != STB) stable_cnt <= stable_cnt + 4'd1;
      end else begin
        cand_w     <= line_w;
        cand_h     <= y_cnt;
        stable_cnt <= 4'd1;
      end
    end
  end

  always_ff @(posedge pixclk_in) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // A candidate change aborts any pending result, even on the last divide cycle.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (frame_end) nxt = MEAS;
      MEAS:    if (stable_cnt == STB &&
                   (cand_w != vin_xres || cand_h != vin_yres || !cfg_valid)) nxt = DIV_W;
      DIV_W:   if (cand_chg) nxt = MEAS; else if (div_cnt == 5'd31) nxt = DIV_H;
      DIV_H:   if (cand_chg) nxt = MEAS; else if (div_cnt == 5'd31) nxt = WAIT_VS;
      WAIT_VS: if (frame_end) nxt = MEAS;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    div_load  = (state == MEAS) && (nxt == DIV_W);
    apply     = (state == WAIT_VS) && frame_end && !cand_chg;
    lock_lost = (state == MEAS) && qual && cfg_valid &&
                (!frame_ok || line_w != vin_xres || y_cnt != vin_yres);
  end

  // Restoring divider: one quotient bit per cycle, remainder always below divisor.
  always_comb begin
    dvsr    = (state == DIV_H) ? VOY : VOX;
    rem_sh  = {rem, dq[31]};
    qbit    = (rem_sh >= {1'b0, dvsr});
    rem_nxt = qbit ? (rem_sh[15:0] - dvsr) : rem_sh[15:0];
    q_nxt   = {dq[30:0], qbit};
  end

  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      dq      <= '0;
      rem     <= '0;
      div_cnt <= '0;
      res_w   <= '0;
      res_h   <= '0;
    end else if (div_load) begin
      dq      <= {cand_w, 16'h0};
      rem     <= '0;
      div_cnt <= '0;
    end else if (state == DIV_W || state == DIV_H) begin
      div_cnt <= div_cnt + 5'd1;
      if (div_cnt == 5'd31) begin
        rem <= '0;
        if (state == DIV_W) begin
          res_w <= q_nxt + 32'd1;
          dq    <= {cand_h, 16'h0};
        end else begin
          res_h <= q_nxt + 32'd1;
          dq    <= q_nxt;
        end
      end else begin
        dq  <= q_nxt;
        rem <= rem_nxt;
      end
    end
  end

  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      vin_xres      <= 16'(DEF_XRES);
      vin_yres      <= 16'(DEF_YRES);
      scaler_width  <= RST_SW;
      scaler_height <= RST_SH;
      cfg_valid     <= 1'b0;
      cfg_update    <= 1'b0;
      fmt_change    <= 1'b0;
    end else begin
      cfg_update <= apply;
      fmt_change <= lock_lost;
      if (apply) begin
        vin_xres      <= cand_w;
        vin_yres      <= cand_h;
        scaler_width  <= res_w;
        scaler_height <= res_h;
        cfg_valid     <= 1'b1;
      end else if (lock_lost) begin
        cfg_valid <= 1'b0;
      end
    end
  end

`ifdef VSCALE_CFG_STATUS_EN
  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      frm_cnt <= '0;
      err_cnt <= '0;
    end else if (qual) begin
      if (frame_ok)                  frm_cnt <= frm_cnt + 16'd1;
      else if (err_cnt != 16'hFFFF)  err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_scale_cfg_ctrl.sv
// Directed bench for video_scale_cfg_ctrl. Resolutions are scaled down (x/160, y/120)
// so the 16.16 factors match the full-size 1080p/720p/480p cases with short frames.
module tb_video_scale_cfg_ctrl;
  logic        clk = 1'b0;
  logic        rst, vs_in, de_in;
  logic [15:0] vin_xres, vin_yres;
  logic [31:0] scaler_width, scaler_height;
  logic        cfg_valid, cfg_update, fmt_change;
`ifdef VSCALE_CFG_STATUS_EN
  logic [15:0] frm_cnt, err_cnt;
`endif

  int n_chk = 0, n_fail = 0;
  int upd_cnt = 0, chg_cnt = 0;
  logic both_seen = 1'b0;

  video_scale_cfg_ctrl #(
    .VOUT_XRES(4), .VOUT_YRES(4), .DEF_XRES(12), .DEF_YRES(9),
    .MAX_XRES(26), .MAX_YRES(18), .STABLE_FRAMES(2)
  ) dut (
    .pixclk_in(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in),
    .vin_xres(vin_xres), .vin_yres(vin_yres),
    .scaler_width(scaler_width), .scaler_height(scaler_height),
    .cfg_valid(cfg_valid), .cfg_update(cfg_update),
`ifdef VSCALE_CFG_STATUS_EN
    .fmt_change(fmt_change), .frm_cnt(frm_cnt), .err_cnt(err_cnt)
`else
    .fmt_change(fmt_change)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_update) upd_cnt <= upd_cnt + 1;
    if (fmt_change) chg_cnt <= chg_cnt + 1;
    if (cfg_update && fmt_change) both_seen <= 1'b1;
  end

  // One frame: active lines, then vs rises (frame end) and stays high for vb cycles.
  task automatic frame(input int w, input int h, input int bad_ln, input int bad_w, input int vb);
    vs_in = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < h; l++) begin
      de_in = 1'b1;
      repeat ((l == bad_ln) ? bad_w : w) @(negedge clk);
      de_in = 1'b0;
      @(negedge clk);
    end
    vs_in = 1'b1;
    repeat (vb) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; vs_in = 1'b0; de_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (vin_xres !== 16'd12) begin n_fail++; $display("FAIL reset_xres got %0d exp 12", vin_xres); end
    n_chk++; if (vin_yres !== 16'd9) begin n_fail++; $display("FAIL reset_yres got %0d exp 9", vin_yres); end
    n_chk++; if (scaler_width !== 32'h00030001) begin n_fail++; $display("FAIL reset_sw got %h exp 00030001", scaler_width); end
    n_chk++; if (scaler_height !== 32'h00024001) begin n_fail++; $display("FAIL reset_sh got %h exp 00024001", scaler_height); end
    n_chk++; if ({cfg_valid, cfg_update, fmt_change} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {cfg_valid, cfg_update, fmt_change}); end
  endtask

  task automatic test_lock_1080;
    int u0;
    u0 = upd_cnt;
    repeat (3) frame(12, 9, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0) begin n_fail++; $display("FAIL lock1080_early got %0d exp %0d", upd_cnt, u0); end
    frame(12, 9, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0 + 1) begin n_fail++; $display("FAIL lock1080_upd got %0d exp %0d", upd_cnt, u0 + 1); end
    n_chk++; if (scaler_width !== 32'h00030001) begin n_fail++; $display("FAIL lock1080_sw got %h exp 00030001", scaler_width); end
    n_chk++; if (scaler_height !== 32'h00024001) begin n_fail++; $display("FAIL lock1080_sh got %h exp 00024001", scaler_height); end
    n_chk++; if (cfg_valid !== 1'b1) begin n_fail++; $display("FAIL lock1080_valid got %b exp 1", cfg_valid); end
  endtask

  task automatic test_switch_720;
    int u0, c0;
    u0 = upd_cnt; c0 = chg_cnt;
    frame(8, 6, -1, 0, 80);
    n_chk++; if (chg_cnt !== c0 + 1) begin n_fail++; $display("FAIL sw720_fmtchg got %0d exp %0d", chg_cnt, c0 + 1); end
    n_chk++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL sw720_valid got %b exp 0", cfg_valid); end
    n_chk++; if (scaler_width !== 32'h00030001) begin n_fail++; $display("FAIL sw720_hold got %h exp 00030001", scaler_width); end
    frame(8, 6, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0) begin n_fail++; $display("FAIL sw720_early got %0d exp %0d", upd_cnt, u0); end
    frame(8, 6, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0 + 1) begin n_fail++; $display("FAIL sw720_upd got %0d exp %0d", upd_cnt, u0 + 1); end
    n_chk++; if (scaler_width !== 32'h00020001) begin n_fail++; $display("FAIL sw720_sw got %h exp 00020001", scaler_width); end
    n_chk++; if (scaler_height !== 32'h00018001) begin n_fail++; $display("FAIL sw720_sh got %h exp 00018001", scaler_height); end
    n_chk++; if ({vin_xres, vin_yres} !== {16'd8, 16'd6}) begin n_fail++; $display("FAIL sw720_res got %0dx%0d exp 8x6", vin_xres, vin_yres); end
  endtask

  task automatic test_bad_line;
    int u0, c0;
`ifdef VSCALE_CFG_STATUS_EN
    logic [15:0] e0;
    e0 = err_cnt;
`endif
    u0 = upd_cnt; c0 = chg_cnt;
    frame(8, 6, 2, 7, 80);
    n_chk++; if (chg_cnt !== c0 + 1) begin n_fail++; $display("FAIL badln_fmtchg got %0d exp %0d", chg_cnt, c0 + 1); end
    n_chk++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL badln_valid got %b exp 0", cfg_valid); end
`ifdef VSCALE_CFG_STATUS_EN
    n_chk++; if (err_cnt !== e0 + 16'd1) begin n_fail++; $display("FAIL badln_errcnt got %0d exp %0d", err_cnt, e0 + 16'd1); end
`endif
    // stable count restarts at 0, so two good frames before the divide, a third to apply
    repeat (2) frame(8, 6, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0) begin n_fail++; $display("FAIL badln_stable got %0d exp %0d", upd_cnt, u0); end
    frame(8, 6, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0 + 1) begin n_fail++; $display("FAIL badln_relock got %0d exp %0d", upd_cnt, u0 + 1); end
    n_chk++; if (cfg_valid !== 1'b1) begin n_fail++; $display("FAIL badln_valid2 got %b exp 1", cfg_valid); end
  endtask

  task automatic test_oversize;
    int u0, c0;
    u0 = upd_cnt; c0 = chg_cnt;
    frame(32, 6, -1, 0, 80);
    n_chk++; if (chg_cnt !== c0 + 1) begin n_fail++; $display("FAIL wide_fmtchg got %0d exp %0d", chg_cnt, c0 + 1); end
    n_chk++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL wide_valid got %b exp 0", cfg_valid); end
    repeat (2) frame(32, 6, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0) begin n_fail++; $display("FAIL wide_upd got %0d exp %0d", upd_cnt, u0); end
    n_chk++; if (chg_cnt !== c0 + 1) begin n_fail++; $display("FAIL wide_fmtchg2 got %0d exp %0d", chg_cnt, c0 + 1); end
  endtask

  task automatic test_div_abort;
    int u0;
    u0 = upd_cnt;
    frame(8, 6, -1, 0, 80);
    // short blanking: the following 4x4 frame ends ~49 cycles into the divide (DIV_H)
    frame(8, 6, -1, 0, 27);
    frame(4, 4, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0) begin n_fail++; $display("FAIL abort_noupd got %0d exp %0d", upd_cnt, u0); end
    frame(4, 4, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0) begin n_fail++; $display("FAIL abort_noupd2 got %0d exp %0d", upd_cnt, u0); end
    n_chk++; if (scaler_width !== 32'h00020001) begin n_fail++; $display("FAIL abort_hold got %h exp 00020001", scaler_width); end
    frame(4, 4, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0 + 1) begin n_fail++; $display("FAIL abort_upd got %0d exp %0d", upd_cnt, u0 + 1); end
    n_chk++; if (scaler_width !== 32'h00010001) begin n_fail++; $display("FAIL abort_sw got %h exp 00010001", scaler_width); end
    n_chk++; if (scaler_height !== 32'h00010001) begin n_fail++; $display("FAIL abort_sh got %h exp 00010001", scaler_height); end
    n_chk++; if ({vin_xres, vin_yres} !== {16'd4, 16'd4}) begin n_fail++; $display("FAIL abort_res got %0dx%0d exp 4x4", vin_xres, vin_yres); end
  endtask

  task automatic test_reset_mid_div;
    int u0;
    frame(8, 6, -1, 0, 80);
    frame(8, 6, -1, 0, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if ({vin_xres, vin_yres} !== {16'd12, 16'd9}) begin n_fail++; $display("FAIL rstdiv_res got %0dx%0d exp 12x9", vin_xres, vin_yres); end
    n_chk++; if (scaler_width !== 32'h00030001) begin n_fail++; $display("FAIL rstdiv_sw got %h exp 00030001", scaler_width); end
    n_chk++; if (scaler_height !== 32'h00024001) begin n_fail++; $display("FAIL rstdiv_sh got %h exp 00024001", scaler_height); end
    n_chk++; if ({cfg_valid, cfg_update, fmt_change} !== 3'b000) begin n_fail++; $display("FAIL rstdiv_flags got %b exp 000", {cfg_valid, cfg_update, fmt_change}); end
    @(negedge clk);
    u0 = upd_cnt;
    repeat (3) frame(8, 6, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0) begin n_fail++; $display("FAIL rstdiv_arm got %0d exp %0d", upd_cnt, u0); end
    frame(8, 6, -1, 0, 80);
    n_chk++; if (upd_cnt !== u0 + 1) begin n_fail++; $display("FAIL rstdiv_upd got %0d exp %0d", upd_cnt, u0 + 1); end
    n_chk++; if (scaler_width !== 32'h00020001) begin n_fail++; $display("FAIL rstdiv_sw2 got %h exp 00020001", scaler_width); end
  endtask

  initial begin
    rst = 1'b1; vs_in = 1'b0; de_in = 1'b0;
    test_reset;
    test_lock_1080;
    test_switch_720;
    test_bad_line;
    test_oversize;
    test_div_abort;
    test_reset_mid_div;
    n_chk++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL upd_chg_overlap got %b exp 0", both_seen); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/video_scale_cfg_ctrl.md
Name: video_scale_cfg_ctrl

Overview:
- Configuration controller for the nearest-neighbour 640x480 scaler.
- Measures the active resolution of the incoming video, qualifies it over consecutive frames and computes the 16.16 horizontal/vertical scale factors with a serial divider.
- Applies the new factors atomically at a frame boundary.
- Sits on pixclk_in beside the scaler, snooping the same vs_in/de_in; its factor outputs drive the scaler's step registers.

Parameters:
- VOUT_XRES, 640, output width; divisor for the horizontal factor.
- VOUT_YRES, 480, output height; divisor for the vertical factor.
- DEF_XRES, 1920, input width assumed out of reset.
- DEF_YRES, 1080, input height assumed out of reset.
- MAX_XRES, 4096, widths above this are rejected.
- MAX_YRES, 2160, heights above this are rejected.
- STABLE_FRAMES, 2, consecutive identical valid frames required before a format is accepted (range 1..15).

Ports:
- pixclk_in  in  1  pixel clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- vs_in  in  1  vertical sync, active high; high = vertical blanking.
- de_in  in  1  data enable, active high.
- vin_xres  out  16  active (applied) input width.
- vin_yres  out  16  active (applied) input height.
- scaler_width  out  32  horizontal step, 16.16 format.
- scaler_height  out  32  vertical step, 16.16 format.
- cfg_valid  out  1  high while the applied config matches the measured input.
- cfg_update  out  1  one-cycle pulse when new factors are applied.
- fmt_change  out  1  one-cycle pulse when a locked format is lost.

Behaviour:
- Reset values (applied on any rst cycle, including mid-divide; all FSM state is aborted to IDLE):
  - vin_xres = DEF_XRES, vin_yres = DEF_YRES
  - scaler_width = ((DEF_XRES<<16)/VOUT_XRES)+1, giving 0x00030001 with default parameters
  - scaler_height = ((DEF_YRES<<16)/VOUT_YRES)+1, giving 0x00024001 with default parameters
  - cfg_valid = 0, cfg_update = 0, fmt_change = 0
- Frame end event: rising edge of vs_in (registered vs_in compared with current vs_in).
  - The first frame end after reset only arms measurement; the partial frame is discarded.
- Measurement:
  - x_cnt increments on each de_in=1 cycle and saturates at 0xFFFF.
  - A line ends on the falling edge of de_in. The first line width in a frame is latched; any later line with a different width sets frame_bad. y_cnt then increments.
  - x_cnt and y_cnt are cleared at frame end.
- Frame qualification at frame end:
  - The frame is invalid if frame_bad is set, width = 0, height = 0, width > MAX_XRES, or height > MAX_YRES.
  - Invalid frame: stable_cnt is cleared to 0.
  - Valid frame equal to the candidate: stable_cnt increments, saturating at STABLE_FRAMES.
  - Valid frame different from the candidate: the candidate is loaded with the new (w,h) and stable_cnt is set to 1.
- FSM states:
  - IDLE: leaves to MEAS after the first frame end.
  - MEAS: moves to DIV_W when stable_cnt == STABLE_FRAMES and the candidate differs from the applied (vin_xres, vin_yres) or cfg_valid = 0.
  - DIV_W: restoring divide of {w,16'h0} by VOUT_XRES, 1 quotient bit per cycle, 32 cycles; result +1. Then DIV_H.
  - DIV_H: the same divide for h and VOUT_YRES, 32 cycles; then WAIT_VS.
  - WAIT_VS: on the next frame end, in the same cycle, register all four outputs, set cfg_valid = 1, pulse cfg_update, and return to MEAS.
  - Measurement keeps running in every state.
- Loss of lock:
  - In MEAS with cfg_valid = 1, the first valid frame whose (w,h) differs from the applied values, or any invalid frame, clears cfg_valid and pulses fmt_change. Outputs hold their old values until a new config is applied.
- Format changes during a divide:
  - If the candidate changes while in DIV_W, DIV_H or WAIT_VS, the pending result is discarded and the FSM returns to MEAS; no cfg_update is issued.
- A frame end that coincides with the last divide cycle: the frame is qualified first, and the discard rule above takes precedence.
- cfg_update and fmt_change never assert in the same cycle.

Optional Feature:
- Macro: VSCALE_CFG_STATUS_EN.
- When defined, two extra output ports are added:
  - frm_cnt, 16 bits: counts qualified frames; wraps 0xFFFF to 0.
  - err_cnt, 16 bits: counts invalid frames; saturates at 0xFFFF.
  - Both reset to 0 on rst.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Test Plan:
1. Reset, then 4 frames of 1920x1080 (STABLE_FRAMES = 2) -> cfg_update pulses once at the 4th vs rise (arm, candidate, stable + divide, apply); scaler_width = 0x00030001, scaler_height = 0x00024001, cfg_valid = 1.
2. Locked at 1920x1080, then switch to 1280x720 -> fmt_change pulse at the first 720p frame end; two frame ends later cfg_update fires with scaler_width = 0x00020001, scaler_height = 0x00018001, vin_xres = 1280, vin_yres = 720.
3. Frame with one 1919-pixel line among 1920-pixel lines -> frame rejected, stable_cnt = 0, cfg_valid drops if locked; err_cnt +1 with the macro defined.
4. 1280x720 candidate changed to 640x480 while in DIV_H -> no cfg_update for 720p; later applied scaler_width = 0x00010001, scaler_height = 0x00010001.
5. Assert rst for 1 cycle mid DIV_W -> the next cycle shows all reset values, FSM in IDLE, and the first following vs rise only arms measurement.
6. Frame 5000 pixels wide -> rejected as > MAX_XRES; no cfg_update.
